// File: rtl/quad_decoder.sv
// Quadrature A/B front end: synchronise, glitch-filter, Gray-decode, and
// accumulate edges into one-cycle up/down command pulses plus a sticky error.
module quad_decoder #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 3,
  parameter int unsigned EDGES_PER_STEP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic enc_a,
  input  logic enc_b,
  input  logic erro_clr,
  output logic acrescer,
  output logic decrecer,
  output logic direcao,
  output logic erro
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned AW = $clog2(EDGES_PER_STEP) + 2;
  localparam logic [CW-1:0]        CNT_MAX = CW'(FILTER_LEN - 1);
  localparam logic signed [AW-1:0] ACC_TOP = AW'(EDGES_PER_STEP - 1);
  localparam logic signed [AW-1:0] ACC_BOT = -ACC_TOP;

  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [1:0]             s;      // {a, b} after synchronisers
  logic [1:0]             f;      // {a, b} after glitch filter
  logic [CW-1:0]          cnt [2];
  logic [1:0]             prev;
  logic signed [AW-1:0]   acc, acc_nxt;
  logic                   fwd, rev, ill;
  logic                   acr_nxt, dec_nxt, dir_nxt, erro_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b};
    end
  end

  assign s = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  // A level is adopted only after it has differed from f for FILTER_LEN cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f      <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (s[i] != f[i]) begin
          if (cnt[i] == CNT_MAX) begin
            f[i]   <= s[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    ill = 1'b0;
    case ({prev, f})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: rev = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: ill = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    acc_nxt  = acc;
    acr_nxt  = 1'b0;
    dec_nxt  = 1'b0;
    dir_nxt  = direcao;
    erro_nxt = erro & ~erro_clr;
    if (ill) erro_nxt = 1'b1;
    if (!enable) begin
      acc_nxt = '0;
    end else if (fwd) begin
      dir_nxt = 1'b1;
      if (acc == ACC_TOP) begin
        acr_nxt = 1'b1;
        acc_nxt = '0;
      end else begin
        acc_nxt = acc + AW'(1);
      end
    end else if (rev) begin
      dir_nxt = 1'b0;
      if (acc == ACC_BOT) begin
        dec_nxt = 1'b1;
        acc_nxt = '0;
      end else begin
        acc_nxt = acc - AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= '0;
      acc      <= '0;
      acrescer <= 1'b0;
      decrecer <= 1'b0;
      direcao  <= 1'b0;
      erro     <= 1'b0;
    end else begin
      prev     <= f;
      acc      <= acc_nxt;
      acrescer <= acr_nxt;
      decrecer <= dec_nxt;
      direcao  <= dir_nxt;
      erro     <= erro_nxt;
    end
  end

endmodule
